// File: rtl/zapper_pkg.sv
// Shared definitions for the Zapper light-sense block and its luma stage.
//   - coordinate width used for raster position, aim point and line/pixel counts
//   - RGB-to-luma weights and normalising shift
//   - sense FSM state encoding
//   - saturating coordinate increment helper
package zapper_pkg;

    localparam int COORD_W    = 9;

    // luma = (LUMA_WR*r + LUMA_WG*g + LUMA_WB*b) >> LUMA_SHIFT
    // The weights sum to 1 << LUMA_SHIFT, so a grey input maps to itself.
    localparam int LUMA_WR    = 2;
    localparam int LUMA_WG    = 5;
    localparam int LUMA_WB    = 1;
    localparam int LUMA_SHIFT = 3;
    localparam int LUMA_SUM_W = 11;

    typedef enum logic [0:0] {
        S_SYNC  = 1'b0,
        S_TRACK = 1'b1
    } zap_state_t;

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/zapper_luma.sv
// Registered RGB-to-luma conversion. Also used by the OSD brightness path.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   ce           load enable; luma only updates when high
//   r, g, b      8-bit colour components
//   luma         registered 8-bit luma, (2r + 5g + b) >> 3
module zapper_luma
    import zapper_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] luma
);

    logic [LUMA_SUM_W-1:0] sum;

    always_comb begin
        sum = LUMA_SUM_W'(LUMA_WR) * LUMA_SUM_W'(r)
            + LUMA_SUM_W'(LUMA_WG) * LUMA_SUM_W'(g)
            + LUMA_SUM_W'(LUMA_WB) * LUMA_SUM_W'(b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            luma <= 8'd0;
        end else if (ce) begin
            luma <= 8'(sum >> LUMA_SHIFT);
        end
    end

endmodule

// File: rtl/zapper_sense.sv
// Light-gun photodiode model. Watches the finished video stream, recovers the
// raster position from DE/VSYNC, and raises 'light' when a bright pixel is
// drawn inside a small square window around the aim point. Once triggered,
// light is held for HOLD_LINES active-line ends, mimicking photodiode decay.
//
// States:
//   S_SYNC  | not locked to a frame yet; detection off, hold counter held at 0
//   S_TRACK | locked after the first vsync rise; normal detection
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   ce_pix         pixel enable; stream inputs are sampled only when high
//   hsync, vsync   active-high syncs
//   de             active video
//   r, g, b        pixel colour
//   aim_x, aim_y   gun aim point in active pixels / active lines
//   light          high while light is sensed
//   frame_valid    last completed frame had at least MIN_LINES active lines
//   active_w       pixel count of the last completed active line
//   active_h       active-line count of the last completed frame
module zapper_sense
    import zapper_pkg::*;
#(
    parameter int RADIUS     = 2,
    parameter int THRESHOLD  = 160,
    parameter int HOLD_LINES = 26,
    parameter int MIN_LINES  = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               de,
    input  logic [7:0]         r,
    input  logic [7:0]         g,
    input  logic [7:0]         b,
    input  logic [COORD_W-1:0] aim_x,
    input  logic [COORD_W-1:0] aim_y,
    output logic               light,
    output logic               frame_valid,
    output logic [COORD_W-1:0] active_w,
    output logic [COORD_W-1:0] active_h
);

    localparam int DW = COORD_W + 1;
    localparam int HW = $clog2(HOLD_LINES + 1);

    localparam logic [DW-1:0]      RAD_U     = DW'(RADIUS);
    localparam logic [7:0]         THR_U     = 8'(THRESHOLD);
    localparam logic [HW-1:0]      HOLD_INIT = HW'(HOLD_LINES);
    localparam logic [COORD_W-1:0] MIN_U     = COORD_W'(MIN_LINES);

    zap_state_t state_q, state_d;
    logic       track;

    logic de_q, vs_q, hs_q;
    logic de_fall, vs_rise, hs_rise;

    logic [COORD_W-1:0] x, y;

    logic signed [DW-1:0] dx, dy;
    logic [DW-1:0]        adx, ady;
    logic                 in_win;
    logic                 in_win_q;
    logic [7:0]           luma_q;
    logic                 bright_hit;

    logic [HW-1:0] hold_cnt;

    // ------------------------------------------------------------------
    // Sync / DE edge detection, all qualified by the pixel enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            de_q <= 1'b0;
            vs_q <= 1'b0;
            hs_q <= 1'b0;
        end else if (ce_pix) begin
            de_q <= de;
            vs_q <= vsync;
            hs_q <= hsync;
        end
    end

    assign de_fall = ce_pix & de_q & ~de;
    assign vs_rise = ce_pix & vsync & ~vs_q;
    assign hs_rise = ce_pix & hsync & ~hs_q;

    // ------------------------------------------------------------------
    // Raster position and frame geometry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            active_w    <= '0;
            active_h    <= '0;
            frame_valid <= 1'b0;
        end else begin
            if (vs_rise) begin
                active_h    <= y;
                frame_valid <= (y >= MIN_U);
                x           <= '0;
                y           <= '0;
            end else if (de_fall) begin
                x <= '0;
                y <= sat_inc(y);
            end else if (hs_rise && !de) begin
                // Re-align the pixel counter at every line start in blanking,
                // so a malformed line cannot leave x offset into the next one.
                x <= '0;
            end else if (ce_pix && de) begin
                x <= sat_inc(x);
            end

            if (de_fall) begin
                active_w <= x;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sense window: signed 10-bit distance so the window clips at the
    // raster edges and an off-raster aim simply never matches.
    // ------------------------------------------------------------------
    always_comb begin
        dx     = $signed({1'b0, x}) - $signed({1'b0, aim_x});
        dy     = $signed({1'b0, y}) - $signed({1'b0, aim_y});
        adx    = dx[DW-1] ? DW'(-dx) : DW'(dx);
        ady    = dy[DW-1] ? DW'(-dy) : DW'(dy);
        in_win = de & (adx <= RAD_U) & (ady <= RAD_U);
    end

    // ------------------------------------------------------------------
    // Stage 1: luma and window flag captured on the pixel enable
    // ------------------------------------------------------------------
    zapper_luma u_luma (
        .clk   (clk),
        .reset (reset),
        .ce    (ce_pix),
        .r     (r),
        .g     (g),
        .b     (b),
        .luma  (luma_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            in_win_q <= 1'b0;
        end else if (ce_pix) begin
            in_win_q <= in_win;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        track   = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (vs_rise) begin
                    state_d = S_TRACK;
                end
            end
            S_TRACK: begin
                track = 1'b1;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2: hold counter. Runs every clk (not gated by ce_pix), so light
    // follows one clk after the stage-1 capture. Reload beats the per-line
    // decrement when both land on the same cycle.
    // ------------------------------------------------------------------
    assign bright_hit = track & in_win_q & (luma_q >= THR_U);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (!track) begin
            hold_cnt <= '0;
        end else if (bright_hit) begin
            hold_cnt <= HOLD_INIT;
        end else if (de_fall && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign light = (hold_cnt != '0);

endmodule

// File: tb/tb_zapper_sense.sv
// Directed bench for zapper_sense: drives whole frames of video and records
// when light first rises (labelled with the last pixel driven) and in which
// line it falls again, then compares against hand-computed expectations.
module tb_zapper_sense;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] r, g, b;
    logic [8:0] aim_x, aim_y;
    logic       light;
    logic       frame_valid;
    logic [8:0] active_w;
    logic [8:0] active_h;

    int checks   = 0;
    int failures = 0;

    int hi_seen, rise_x, rise_y, fall_line, hi_after_rst, after_rst;
    int lab_x = -1, lab_y = -1;

    always #5 clk = ~clk;

    zapper_sense dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .r           (r),
        .g           (g),
        .b           (b),
        .aim_x       (aim_x),
        .aim_y       (aim_y),
        .light       (light),
        .frame_valid (frame_valid),
        .active_w    (active_w),
        .active_h    (active_h)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Observe light at the falling edge, then drive the next cycle's inputs.
    task automatic step(input logic de_i, input logic vs_i, input logic hs_i,
                        input logic ce_i, input logic [7:0] v,
                        input int lx, input int ly);
        @(negedge clk);
        if (light === 1'b1) begin
            if (hi_seen == 0) begin
                hi_seen = 1;
                rise_x  = lab_x;
                rise_y  = lab_y;
            end
            if (after_rst != 0) hi_after_rst = 1;
        end else if (hi_seen != 0 && fall_line < 0) begin
            fall_line = lab_y;
        end
        de     = de_i;
        vsync  = vs_i;
        hsync  = hs_i;
        ce_pix = ce_i;
        r      = v;
        g      = v;
        b      = v;
        lab_x  = lx;
        lab_y  = ly;
    endtask

    // One pixel or blank slot: ce_div clocks, pixel enable on the first.
    task automatic unit(input logic de_i, input logic vs_i, input logic hs_i,
                        input int ce_div, input logic [7:0] v,
                        input int lx, input int ly);
        for (int k = 0; k < ce_div; k++) begin
            step(de_i, vs_i, hs_i, (k == 0), v, lx, ly);
        end
    endtask

    // mode 0: every pixel = val; mode 1: only pixel (px,py) is white.
    task automatic run_frame(input int w, input int h, input int ce_div,
                             input int mode, input logic [7:0] val,
                             input int px, input int py, input int rst_line);
        logic [7:0] pix;
        hi_seen      = 0;
        rise_x       = -1;
        rise_y       = -1;
        fall_line    = -1;
        hi_after_rst = 0;
        after_rst    = 0;
        for (int ln = 0; ln < h; ln++) begin
            if (ln == rst_line) begin
                @(negedge clk);
                reset  = 1'b1;
                de     = 1'b0;
                ce_pix = 1'b1;
                @(negedge clk);
                check("light_low_clk_after_reset", int'(light), 0);
                reset     = 1'b0;
                after_rst = 1;
            end
            for (int px_i = 0; px_i < w; px_i++) begin
                if (mode == 0) pix = val;
                else           pix = (px_i == px && ln == py) ? 8'hFF : 8'h00;
                unit(1'b1, 1'b0, 1'b0, ce_div, pix, px_i, ln);
            end
            unit(1'b0, 1'b0, 1'b0, ce_div, 8'h00, -1, ln);
            unit(1'b0, 1'b0, 1'b1, ce_div, 8'h00, -1, ln);
        end
        for (int k = 0; k < 2; k++) unit(1'b0, 1'b0, 1'b0, ce_div, 8'h00, -1, h);
        for (int k = 0; k < 2; k++) unit(1'b0, 1'b1, 1'b0, ce_div, 8'h00, -1, h);
        for (int k = 0; k < 2; k++) unit(1'b0, 1'b0, 1'b0, ce_div, 8'h00, -1, h);
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b0;
        hsync  = 1'b0;
        vsync  = 1'b0;
        de     = 1'b0;
        r      = 8'h00;
        g      = 8'h00;
        b      = 8'h00;
        aim_x  = 9'd8;
        aim_y  = 9'd6;
        repeat (3) @(negedge clk);
        check("reset_light",       int'(light), 0);
        check("reset_frame_valid", int'(frame_valid), 0);
        check("reset_active_w",    int'(active_w), 0);
        check("reset_active_h",    int'(active_h), 0);
        reset = 1'b0;

        // Not yet locked: white over the aim point must not light.
        run_frame(14, 36, 1, 0, 8'hFF, 0, 0, -1);
        check("sync_state_no_light", hi_seen, 0);
        check("f1_active_w", int'(active_w), 14);
        check("f1_active_h", int'(active_h), 36);
        check("f1_frame_valid", int'(frame_valid), 0);

        // Full 256x240 white frame, aim (128,120).
        aim_x = 9'd128;
        aim_y = 9'd120;
        run_frame(256, 240, 1, 0, 8'hFF, 0, 0, -1);
        check("white_light_rose", hi_seen, 1);
        check("white_rise_x", rise_x, 127);
        check("white_rise_y", rise_y, 118);
        check("white_fall_line", fall_line, 147);
        check("full_active_w", int'(active_w), 256);
        check("full_active_h", int'(active_h), 240);
        check("full_frame_valid", int'(frame_valid), 1);

        aim_x = 9'd8;
        aim_y = 9'd6;
        run_frame(14, 36, 1, 0, 8'h00, 0, 0, -1);
        check("black_no_light", hi_seen, 0);
        check("black_active_w", int'(active_w), 14);
        check("black_frame_valid", int'(frame_valid), 0);

        // Single white pixel against the window boundaries.
        run_frame(14, 36, 1, 1, 8'h00, 10, 6, -1);
        check("pix_10_6_light", hi_seen, 1);
        check("pix_10_6_rise_x", rise_x, 11);
        check("pix_10_6_rise_y", rise_y, 6);
        check("pix_10_6_fall_line", fall_line, 31);
        run_frame(14, 36, 1, 1, 8'h00, 11, 6, -1);
        check("pix_11_6_dark", hi_seen, 0);
        run_frame(14, 36, 1, 1, 8'h00, 5, 6, -1);
        check("pix_5_6_dark", hi_seen, 0);
        run_frame(14, 36, 1, 1, 8'h00, 8, 3, -1);
        check("pix_8_3_dark", hi_seen, 0);
        run_frame(14, 36, 1, 1, 8'h00, 6, 8, -1);
        check("pix_6_8_light", hi_seen, 1);
        check("pix_6_8_rise_x", rise_x, 7);
        check("pix_6_8_rise_y", rise_y, 8);

        // Threshold boundary on grey.
        run_frame(14, 36, 1, 0, 8'd159, 0, 0, -1);
        check("grey159_dark", hi_seen, 0);
        run_frame(14, 36, 1, 0, 8'd160, 0, 0, -1);
        check("grey160_light", hi_seen, 1);
        check("grey160_rise_x", rise_x, 7);
        check("grey160_rise_y", rise_y, 4);
        check("grey160_fall_line", fall_line, 33);

        // Aim outside the raster never matches.
        aim_x = 9'd300;
        aim_y = 9'd300;
        run_frame(14, 36, 1, 0, 8'hFF, 0, 0, -1);
        check("aim_off_raster_dark", hi_seen, 0);
        aim_x = 9'd8;
        aim_y = 9'd6;

        // frame_valid around MIN_LINES.
        run_frame(2, 150, 1, 0, 8'h00, 0, 0, -1);
        check("h150_active_h", int'(active_h), 150);
        check("h150_frame_valid", int'(frame_valid), 0);
        check("h150_active_w", int'(active_w), 2);
        run_frame(2, 199, 1, 0, 8'h00, 0, 0, -1);
        check("h199_frame_valid", int'(frame_valid), 0);
        run_frame(2, 200, 1, 0, 8'h00, 0, 0, -1);
        check("h200_frame_valid", int'(frame_valid), 1);

        // Pixel enable every other clk: stage 2 still fires one clk later.
        run_frame(14, 36, 2, 0, 8'hFF, 0, 0, -1);
        check("ce2_light", hi_seen, 1);
        check("ce2_rise_x", rise_x, 6);
        check("ce2_rise_y", rise_y, 4);
        check("ce2_fall_line", fall_line, 33);
        check("ce2_active_w", int'(active_w), 14);

        // Reset pulse mid-frame while light is high.
        run_frame(14, 36, 1, 0, 8'hFF, 0, 0, 10);
        check("rst_light_before", hi_seen, 1);
        check("rst_no_light_after", hi_after_rst, 0);
        check("rst_active_h", int'(active_h), 26);
        check("rst_frame_valid", int'(frame_valid), 0);
        run_frame(14, 36, 1, 0, 8'hFF, 0, 0, -1);
        check("post_rst_light", hi_seen, 1);
        check("post_rst_rise_x", rise_x, 7);
        check("post_rst_rise_y", rise_y, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
